// File: rtl/io_debounce_pkg.sv
// Shared constants for the button/switch input conditioner: default channel counts,
// board button indices and the counter sizing helper.
package io_debounce_pkg;

    localparam int unsigned N_BTN_DEF = 32'd5;
    localparam int unsigned N_SW_DEF  = 32'd16;

    typedef enum int unsigned {
        BTN_C = 32'd0,
        BTN_U = 32'd1,
        BTN_D = 32'd2,
        BTN_L = 32'd3,
        BTN_R = 32'd4
    } btn_idx_e;

    // Bits needed for a counter that runs 0..limit-1; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned limit);
        if (limit <= 32'd1) begin
            return 32'd1;
        end else begin
            return $clog2(limit);
        end
    endfunction

endpackage

// File: rtl/debounce_ch.sv
// One input channel: two-flop synchroniser, tick-qualified stability counter and
// registered stable level with a rising-edge pulse aligned to the level change.
module debounce_ch
    import io_debounce_pkg::*;
#(
    parameter int unsigned STABLE_TICKS = 32'd10
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic raw,
    output logic stable,
    output logic rise
);

    localparam int unsigned      CW       = cnt_width(STABLE_TICKS);
    localparam logic [CW-1:0]    CNT_LAST = CW'(STABLE_TICKS - 32'd1);
    localparam logic [CW-1:0]    CNT_ONE  = CW'(32'd1);

    logic          sync1_r;
    logic          sync2_r;
    logic [CW-1:0] cnt_r;
    logic          stable_r;
    logic          rise_r;

    // Two-stage synchroniser for the asynchronous raw input.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= raw;
            sync2_r <= sync1_r;
        end
    end

    // Accept a new level only after STABLE_TICKS consecutive mismatching ticks;
    // any matching tick restarts the count so short glitches are discarded.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r    <= {CW{1'b0}};
            stable_r <= 1'b0;
            rise_r   <= 1'b0;
        end else begin
            rise_r <= 1'b0;
            if (tick) begin
                if (sync2_r == stable_r) begin
                    cnt_r <= {CW{1'b0}};
                end else if (cnt_r == CNT_LAST) begin
                    stable_r <= sync2_r;
                    rise_r   <= sync2_r;
                    cnt_r    <= {CW{1'b0}};
                end else begin
                    cnt_r <= cnt_r + CNT_ONE;
                end
            end
        end
    end

    assign stable = stable_r;
    assign rise   = rise_r;

endmodule

// File: rtl/btn_sw_debounce_ctrl.sv
// Button/switch conditioner: shared sample-tick divider, per-channel debouncers, press
// pulses and a sticky CPU-clearable event register. Define AUTOREPEAT_EN for held-button repeats.
module btn_sw_debounce_ctrl
    import io_debounce_pkg::*;
#(
    parameter int unsigned N_BTN         = N_BTN_DEF,
    parameter int unsigned N_SW          = N_SW_DEF,
    parameter int unsigned TICK_DIV      = 32'd100000,
    parameter int unsigned STABLE_TICKS  = 32'd10
`ifdef AUTOREPEAT_EN
    ,
    parameter int unsigned REPEAT_DELAY  = 32'd50,
    parameter int unsigned REPEAT_PERIOD = 32'd10
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] BTN,
    input  logic [N_SW-1:0]  SW,
    output logic [N_BTN-1:0] BTN_out,
    output logic [N_SW-1:0]  SW_out,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_evt,
    output logic             btn_evt_any,
    input  logic             evt_clr,
    input  logic [N_BTN-1:0] evt_clr_mask
);

    localparam int unsigned   N_CH      = N_BTN + N_SW;
    localparam int unsigned   TW        = cnt_width(TICK_DIV);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 32'd1);
    localparam logic [TW-1:0] TICK_ONE  = TW'(32'd1);

    logic [TW-1:0]    tick_cnt_r;
    logic             tick_s;
    logic [N_CH-1:0]  raw_s;
    logic [N_CH-1:0]  stable_s;
    logic [N_CH-1:0]  rise_s;
    logic [N_BTN-1:0] btn_rise_s;
    logic [N_SW-1:0]  sw_rise_unused;
    logic [N_BTN-1:0] press_s;
    logic [N_BTN-1:0] clr_s;
    logic [N_BTN-1:0] evt_next_s;
    logic [N_BTN-1:0] btn_evt_r;
    logic             btn_evt_any_r;

    // Free-running sample divider; tick is high while the count sits on its last value.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt_r <= {TW{1'b0}};
        end else if (tick_s) begin
            tick_cnt_r <= {TW{1'b0}};
        end else begin
            tick_cnt_r <= tick_cnt_r + TICK_ONE;
        end
    end

    assign tick_s = (tick_cnt_r == TICK_LAST);
    assign raw_s  = {SW, BTN};

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        debounce_ch #(
            .STABLE_TICKS(STABLE_TICKS)
        ) u_ch (
            .clk   (clk),
            .rst   (rst),
            .tick  (tick_s),
            .raw   (raw_s[i]),
            .stable(stable_s[i]),
            .rise  (rise_s[i])
        );
    end

    assign BTN_out        = stable_s[N_BTN-1:0];
    assign SW_out         = stable_s[N_CH-1:N_BTN];
    assign btn_rise_s     = rise_s[N_BTN-1:0];
    assign sw_rise_unused = rise_s[N_CH-1:N_BTN];

`ifdef AUTOREPEAT_EN
    localparam int unsigned   RW          = cnt_width((REPEAT_DELAY > REPEAT_PERIOD) ?
                                                      REPEAT_DELAY : REPEAT_PERIOD);
    localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 32'd1);
    localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 32'd1);
    localparam logic [RW-1:0] REP_ONE     = RW'(32'd1);

    logic [N_BTN-1:0] rep_fire_s;

    for (genvar i = 0; i < N_BTN; i++) begin : g_rep
        logic [RW-1:0] rep_cnt_r;
        logic          after_first_r;
        logic          fire_r;

        // Count ticks while the button is held: first repeat after the delay, then each period.
        always_ff @(posedge clk) begin
            if (rst) begin
                rep_cnt_r     <= {RW{1'b0}};
                after_first_r <= 1'b0;
                fire_r        <= 1'b0;
            end else if (!stable_s[i]) begin
                rep_cnt_r     <= {RW{1'b0}};
                after_first_r <= 1'b0;
                fire_r        <= 1'b0;
            end else begin
                fire_r <= 1'b0;
                if (tick_s) begin
                    if (rep_cnt_r == (after_first_r ? PERIOD_LAST : DELAY_LAST)) begin
                        fire_r        <= 1'b1;
                        after_first_r <= 1'b1;
                        rep_cnt_r     <= {RW{1'b0}};
                    end else begin
                        rep_cnt_r <= rep_cnt_r + REP_ONE;
                    end
                end
            end
        end

        assign rep_fire_s[i] = fire_r;
    end

    // A repeat that lands on the release tick is masked by the now-low level.
    assign press_s = btn_rise_s | (rep_fire_s & stable_s[N_BTN-1:0]);
`else
    assign press_s = btn_rise_s;
`endif

    // Clear mask only applies while the strobe is high.
    always_comb begin
        if (evt_clr) begin
            clr_s = evt_clr_mask;
        end else begin
            clr_s = {N_BTN{1'b0}};
        end
    end

    // Press has priority over a simultaneous clear of the same bit.
    assign evt_next_s = (btn_evt_r & ~clr_s) | press_s;

    // Sticky event flags and their summary bit, both updated from the same next value.
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_evt_r     <= {N_BTN{1'b0}};
            btn_evt_any_r <= 1'b0;
        end else begin
            btn_evt_r     <= evt_next_s;
            btn_evt_any_r <= |evt_next_s;
        end
    end

    assign btn_press   = press_s;
    assign btn_evt     = btn_evt_r;
    assign btn_evt_any = btn_evt_any_r;

endmodule
